// File: rtl/vref_trim_pkg.sv
// rtl/vref_trim_pkg.sv - shared types and constants for the bandgap trim sequencer
package vref_trim_pkg;

    localparam int TRIM_W = 8;
    localparam logic [TRIM_W-1:0] TRIM_MID = 8'h80;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SAR    = 2'b01,
        MODE_SWEEP  = 2'b10,
        MODE_OFF    = 2'b11
    } mode_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_MANUAL,
        ST_SAR_SET,
        ST_SAR_WAIT,
        ST_SAR_DECIDE,
        ST_SWP_HOLD,
        ST_SWP_NEXT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vref_trim_seq_sync2.sv
// rtl/vref_trim_seq_sync2.sv - two-flop synchroniser for the asynchronous comparator input
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vref_trim_seq.sv
// rtl/vref_trim_seq.sv - bandgap power-up, manual hold, SAR trim and code sweep sequencer
module vref_trim_seq
    import vref_trim_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024,
    parameter int STEP_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] manual_trim,
    input  logic [1:0] manual_sel,
    input  logic       comp_in,
    output logic       bg_en,
    output logic [7:0] trim,
    output logic       sel_bg,
    output logic       sel_iout,
    output logic       busy,
    output logic       done,
    output logic       sample
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int TW = $clog2(STEP_CYCLES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] STEP_LOAD   = TW'(STEP_CYCLES - 1);

    state_t        state;
    mode_t         mode_q;
    mode_t         mode_in;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] step_cnt;
    logic [2:0]    bit_idx;
    logic          comp_s;

    assign mode_in = mode_t'(mode);

    sync2 u_comp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (comp_in),
        .q     (comp_s)
    );

    // Abort shares the reset path so that no partial trim state survives it.
    always_ff @(posedge clk) begin
        if (!rst_n || mode_in == MODE_OFF) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_MANUAL;
            settle_cnt <= '0;
            step_cnt   <= '0;
            bit_idx    <= 3'd7;
            bg_en      <= 1'b0;
            trim       <= TRIM_MID;
            sel_bg     <= 1'b0;
            sel_iout   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample     <= 1'b0;
        end else begin
            sample <= 1'b0;
            if ((state == ST_IDLE || state == ST_DONE) && start) begin
                state      <= ST_PWRUP;
                mode_q     <= mode_in;
                settle_cnt <= SETTLE_LOAD;
                step_cnt   <= '0;
                bit_idx    <= 3'd7;
                bg_en      <= 1'b1;
                busy       <= 1'b1;
                done       <= 1'b0;
                sel_bg     <= 1'b0;
                sel_iout   <= 1'b0;
                trim       <= (mode_in == MODE_SWEEP) ? '0 : TRIM_MID;
            end else begin
                case (state)
                    ST_PWRUP: begin
                        if (settle_cnt == '0) begin
                            case (mode_q)
                                MODE_MANUAL: state <= ST_MANUAL;
                                MODE_SAR: begin
                                    state  <= ST_SAR_SET;
                                    sel_bg <= 1'b1;
                                end
                                default: begin
                                    state    <= ST_SWP_HOLD;
                                    step_cnt <= STEP_LOAD;
                                    sel_bg   <= 1'b1;
                                end
                            endcase
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    ST_MANUAL: begin
                        trim     <= manual_trim;
                        sel_bg   <= manual_sel[0];
                        sel_iout <= manual_sel[1];
                    end
                    ST_SAR_SET: begin
                        trim[bit_idx] <= 1'b1;
                        step_cnt      <= STEP_LOAD;
                        state         <= ST_SAR_WAIT;
                    end
                    ST_SAR_WAIT: begin
                        if (step_cnt == '0) state <= ST_SAR_DECIDE;
                        else step_cnt <= step_cnt - 1'b1;
                    end
                    ST_SAR_DECIDE: begin
                        if (comp_s) trim[bit_idx] <= 1'b0;
                        if (bit_idx == 3'd0) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                            state   <= ST_SAR_SET;
                        end
                    end
                    ST_SWP_HOLD: begin
                        // Registered strobe, so raise it one count early to land in the last hold cycle.
                        sample <= (step_cnt == TW'(1));
                        if (step_cnt == '0) state <= ST_SWP_NEXT;
                        else step_cnt <= step_cnt - 1'b1;
                    end
                    ST_SWP_NEXT: begin
                        if (trim == {TRIM_W{1'b1}}) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            trim     <= trim + 1'b1;
                            step_cnt <= STEP_LOAD;
                            state    <= ST_SWP_HOLD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vref_trim_seq.sv
// tb/tb_vref_trim_seq.sv - randomized self-checking bench for vref_trim_seq
module tb_vref_trim_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [7:0] manual_trim;
    logic [1:0] manual_sel;
    logic       comp_a;
    logic       comp_b;
    logic [7:0] tgt_a;
    logic       glitch_on;
    logic       glitch_v;

    logic       bg_en_a, sel_bg_a, sel_iout_a, busy_a, done_a, sample_a;
    logic [7:0] trim_a;
    logic       bg_en_b, sel_bg_b, sel_iout_b, busy_b, done_b, sample_b;
    logic [7:0] trim_b;

    int n_cmp;
    int n_bad;

    assign comp_a = glitch_on ? glitch_v : (trim_a > tgt_a);

    vref_trim_seq #(.SETTLE_CYCLES(16), .STEP_CYCLES(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .manual_trim(manual_trim), .manual_sel(manual_sel), .comp_in(comp_a),
        .bg_en(bg_en_a), .trim(trim_a), .sel_bg(sel_bg_a), .sel_iout(sel_iout_a),
        .busy(busy_a), .done(done_a), .sample(sample_a)
    );

    vref_trim_seq #(.SETTLE_CYCLES(16), .STEP_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .manual_trim(manual_trim), .manual_sel(manual_sel), .comp_in(comp_b),
        .bg_en(bg_en_b), .trim(trim_b), .sel_bg(sel_bg_b), .sel_iout(sel_iout_b),
        .busy(busy_b), .done(done_b), .sample(sample_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal SAR against a comparator that reads 1 above threshold t.
    function automatic logic [63:0] sar_trials(input logic [7:0] t);
        logic [7:0] code;
        logic [7:0] trial;
        code = 8'h00;
        sar_trials = '0;
        for (int k = 7; k >= 0; k--) begin
            trial = code | (8'h01 << k);
            sar_trials[8*(7-k) +: 8] = trial;
            if (trial <= t) code = trial;
        end
    endfunction

    task automatic go_idle;
        start = 1'b0;
        mode  = 2'b11;
        @(posedge clk); #1;
        mode  = 2'b01;
    endtask

    task automatic run_sar(input logic [7:0] tgt, input bit glitch, input bit poke,
                           output int done_e, output logic [63:0] trials,
                           output logic [7:0] fin, output bit bg_low);
        int p;
        int b;
        int d1;
        tgt_a = tgt; glitch_on = 1'b0; done_e = 0; bg_low = 1'b0; trials = '0;
        mode = 2'b01; start = 1'b1;
        for (int e = 1; e <= 150 && done_e == 0; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            glitch_on = 1'b0;
            if (!bg_en_a) bg_low = 1'b1;
            if (done_a) done_e = e;
            if (e >= 17) begin
                p = (e - 17) % 10;
                b = (e - 17) / 10;
                if (b < 8) begin
                    if (p == 1) trials[8*b +: 8] = trim_a;
                    if (poke && b == 2 && p == 4) start = 1'b1;
                    if (glitch && p >= 1 && p <= 3) begin
                        glitch_on = 1'b1;
                        glitch_v = 1'($urandom);
                        d1 = $urandom_range(1, 5);
                        #(d1) glitch_v = ~glitch_v;
                        #(7 - d1) glitch_v = 1'($urandom);
                        #1 glitch_v = 1'($urandom);
                    end
                end
            end
        end
        fin = trim_a;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; mode = 2'b00;
        manual_trim = 8'h00; manual_sel = 2'b00;
        comp_b = 1'b0; tgt_a = 8'h00; glitch_on = 1'b0; glitch_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bg_en_a, trim_a, sel_bg_a, sel_iout_a, busy_a, done_a, sample_a} !== {1'b0, 8'h80, 5'b0}) begin
            n_bad++; $display("FAIL reset_a: got bg=%b trim=%h sel=%b%b busy=%b done=%b smp=%b want 0 80 00 0 0 0",
                bg_en_a, trim_a, sel_iout_a, sel_bg_a, busy_a, done_a, sample_a);
        end
        n_cmp++;
        if ({bg_en_b, trim_b, sel_bg_b, sel_iout_b, busy_b, done_b, sample_b} !== {1'b0, 8'h80, 5'b0}) begin
            n_bad++; $display("FAIL reset_b: got bg=%b trim=%h busy=%b done=%b want 0 80 0 0", bg_en_b, trim_b, busy_b, done_b);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bg_en_a, busy_a} !== 2'b00) begin
            n_bad++; $display("FAIL idle_hold: got bg=%b busy=%b want 0 0", bg_en_a, busy_a);
        end
    endtask

    task automatic test_sar;
        int done_e;
        logic [63:0] trials;
        logic [63:0] spec_seq;
        logic [7:0] fin;
        bit bg_low;
        go_idle();
        spec_seq = 64'h5B5A5C5850604080;
        run_sar(8'h5A, 1'b0, 1'b0, done_e, trials, fin, bg_low);
        n_cmp++;
        if (done_e != 97) begin n_bad++; $display("FAIL sar_latency: got %0d want 97", done_e); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (trials[8*i +: 8] !== spec_seq[8*i +: 8]) begin
                n_bad++; $display("FAIL sar_trial%0d: got %h want %h", i, trials[8*i +: 8], spec_seq[8*i +: 8]);
            end
        end
        n_cmp++;
        if (fin !== 8'h5A) begin n_bad++; $display("FAIL sar_result: got %h want 5a", fin); end
        n_cmp++;
        if ({bg_en_a, sel_bg_a, sel_iout_a, busy_a} !== 4'b1100) begin
            n_bad++; $display("FAIL sar_done_outputs: got bg=%b sbg=%b siout=%b busy=%b want 1 1 0 0",
                bg_en_a, sel_bg_a, sel_iout_a, busy_a);
        end
    endtask

    task automatic test_back_to_back;
        int done_e;
        logic [63:0] trials;
        logic [7:0] fin;
        logic [7:0] t;
        bit bg_low;
        t = 8'($urandom);
        run_sar(t, 1'b0, 1'b0, done_e, trials, fin, bg_low);
        n_cmp++;
        if (done_e != 97) begin n_bad++; $display("FAIL b2b_latency: got %0d want 97", done_e); end
        n_cmp++;
        if (bg_low) begin n_bad++; $display("FAIL b2b_bg_en: got dropped want held 1"); end
        n_cmp++;
        if (fin !== t) begin n_bad++; $display("FAIL b2b_result: got %h want %h", fin, t); end
    endtask

    task automatic test_sar_random;
        int done_e;
        logic [63:0] trials;
        logic [7:0] fin;
        logic [7:0] t;
        bit bg_low;
        for (int i = 0; i < 5; i++) begin
            t = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom);
            go_idle();
            run_sar(t, 1'b1, (i >= 2), done_e, trials, fin, bg_low);
            n_cmp++;
            if (done_e != 97) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want 97", i, done_e); end
            n_cmp++;
            if (trials !== sar_trials(t)) begin
                n_bad++; $display("FAIL rnd_trials[%0d]: got %h want %h", i, trials, sar_trials(t));
            end
            n_cmp++;
            if (fin !== t) begin n_bad++; $display("FAIL rnd_result[%0d]: got %h want %h", i, fin, t); end
        end
    endtask

    task automatic test_sweep;
        int q;
        int trim_bad;
        int samp_cnt;
        int samp_bad;
        int done_e;
        logic [7:0] exp_trim;
        logic exp_samp;
        trim_bad = 0; samp_cnt = 0; samp_bad = 0; done_e = 0;
        go_idle();
        mode = 2'b10; start = 1'b1;
        for (int e = 1; e <= 1310; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            q = e - 17;
            exp_trim = (e < 17) ? 8'h00 : (q / 5 > 255) ? 8'hFF : 8'(q / 5);
            exp_samp = (e >= 17) && (q < 1280) && (q % 5 == 3);
            if (trim_b !== exp_trim) trim_bad++;
            if (sample_b) samp_cnt++;
            if (sample_b !== exp_samp) samp_bad++;
            if (done_b && done_e == 0) done_e = e;
        end
        n_cmp++;
        if (trim_bad != 0) begin n_bad++; $display("FAIL swp_trim_seq: got %0d bad cycles want 0", trim_bad); end
        n_cmp++;
        if (samp_cnt != 256) begin n_bad++; $display("FAIL swp_sample_count: got %0d want 256", samp_cnt); end
        n_cmp++;
        if (samp_bad != 0) begin n_bad++; $display("FAIL swp_sample_place: got %0d bad cycles want 0", samp_bad); end
        n_cmp++;
        if (done_e != 1297) begin n_bad++; $display("FAIL swp_latency: got %0d want 1297", done_e); end
        n_cmp++;
        if ({trim_b, busy_b, bg_en_b} !== {8'hFF, 2'b01}) begin
            n_bad++; $display("FAIL swp_end: got trim=%h busy=%b bg=%b want ff 0 1", trim_b, busy_b, bg_en_b);
        end
    endtask

    task automatic test_manual;
        logic [7:0] v;
        logic [1:0] s;
        go_idle();
        manual_trim = 8'h11; manual_sel = 2'b01; mode = 2'b00; start = 1'b1;
        repeat (18) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_cmp++;
        if ({trim_a, sel_iout_a, sel_bg_a, busy_a, done_a} !== {8'h11, 2'b01, 2'b10}) begin
            n_bad++; $display("FAIL man_enter: got trim=%h sel=%b%b busy=%b done=%b want 11 01 1 0",
                trim_a, sel_iout_a, sel_bg_a, busy_a, done_a);
        end
        manual_trim = 8'hC3; manual_sel = 2'b10;
        #2;
        n_cmp++;
        if (trim_a !== 8'h11) begin n_bad++; $display("FAIL man_no_comb: got %h want 11", trim_a); end
        @(posedge clk); #1;
        n_cmp++;
        if ({trim_a, sel_iout_a, sel_bg_a} !== {8'hC3, 2'b10}) begin
            n_bad++; $display("FAIL man_c3: got trim=%h siout=%b sbg=%b want c3 1 0", trim_a, sel_iout_a, sel_bg_a);
        end
        mode = 2'b01;
        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom); s = 2'($urandom);
            manual_trim = v; manual_sel = s;
            @(posedge clk); #1;
            n_cmp++;
            if ({trim_a, sel_iout_a, sel_bg_a, done_a, busy_a} !== {v, s, 2'b01}) begin
                n_bad++; $display("FAIL man_follow[%0d]: got trim=%h sel=%b%b done=%b busy=%b want %h %b 0 1",
                    i, trim_a, sel_iout_a, sel_bg_a, done_a, busy_a, v, s);
            end
        end
    endtask

    task automatic test_abort;
        int done_e;
        logic [63:0] trials;
        logic [7:0] fin;
        logic [7:0] t;
        bit bg_low;
        go_idle();
        tgt_a = 8'($urandom); mode = 2'b01; start = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_cmp++;
        if ({busy_a, trim_a[3]} !== 2'b11) begin
            n_bad++; $display("FAIL abort_pre: got busy=%b trim3=%b want 1 1", busy_a, trim_a[3]);
        end
        mode = 2'b11;
        @(posedge clk); #1;
        mode = 2'b01;
        n_cmp++;
        if ({bg_en_a, trim_a, sel_bg_a, sel_iout_a, busy_a, done_a} !== {1'b0, 8'h80, 4'b0}) begin
            n_bad++; $display("FAIL abort_state: got bg=%b trim=%h sel=%b%b busy=%b done=%b want 0 80 00 0 0",
                bg_en_a, trim_a, sel_iout_a, sel_bg_a, busy_a, done_a);
        end
        t = 8'($urandom);
        run_sar(t, 1'b0, 1'b0, done_e, trials, fin, bg_low);
        n_cmp++;
        if (done_e != 97 || fin !== t) begin
            n_bad++; $display("FAIL abort_restart: got latency=%0d trim=%h want 97 %h", done_e, fin, t);
        end
    endtask

    task automatic test_reset_mid;
        go_idle();
        mode = 2'b10; start = 1'b1;
        for (int e = 1; e <= 53; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({trim_b, bg_en_b, busy_b} !== {8'h07, 2'b11}) begin
            n_bad++; $display("FAIL rst_before_edge: got trim=%h bg=%b busy=%b want 07 1 1", trim_b, bg_en_b, busy_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++;
        if ({bg_en_b, trim_b, sel_bg_b, sel_iout_b, busy_b, done_b, sample_b} !== {1'b0, 8'h80, 5'b0}) begin
            n_bad++; $display("FAIL rst_after_edge_b: got bg=%b trim=%h sel=%b%b busy=%b done=%b smp=%b want 0 80 00 0 0 0",
                bg_en_b, trim_b, sel_iout_b, sel_bg_b, busy_b, done_b, sample_b);
        end
        n_cmp++;
        if ({bg_en_a, trim_a, sel_bg_a, busy_a} !== {1'b0, 8'h80, 2'b0}) begin
            n_bad++; $display("FAIL rst_after_edge_a: got bg=%b trim=%h busy=%b want 0 80 0", bg_en_a, trim_a, busy_a);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bg_en_b, busy_b, trim_b} !== {2'b00, 8'h80}) begin
            n_bad++; $display("FAIL rst_stays_idle: got bg=%b busy=%b trim=%h want 0 0 80", bg_en_b, busy_b, trim_b);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_sar();
        test_back_to_back();
        test_sar_random();
        test_sweep();
        test_manual();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
